rgb_wheel_sequencer: RTL
========================

Name: rgb_wheel_sequencer

Overview:
- Controller that sequences the on-board RGB LED through a six-phase colour wheel (red, yellow, green, cyan, blue, magenta) at a fixed step rate.
- Adds global brightness via 8-bit PWM.
- Accepts run, pause, single-step and brightness commands over a valid/ready handshake.
- Sits between the board-level command source (button debouncer or UART decoder) and the active-low LED pins.

Parameters:
- CLK_HZ, 12000000, input clock frequency in Hz.
- STEPS_PER_SEC, 6, colour phases per second; STEP_TICKS = CLK_HZ / STEPS_PER_SEC (2,000,000 at default).
- PWM_BITS, 8, brightness resolution; PWM period = 2**PWM_BITS cycles.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted when cmd_valid & cmd_ready.
- cmd_op  input  2  0=RUN, 1=PAUSE, 2=STEP, 3=SET_BRIGHT.
- cmd_data  input  PWM_BITS  brightness value, used only by SET_BRIGHT.
- phase  output  3  current wheel phase, 0..5.
- running  output  1  1 in RUN state.
- RGB_R  output  1  red LED, active-low.
- RGB_G  output  1  green LED, active-low.
- RGB_B  output  1  blue LED, active-low.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous assert, synchronous deassert at the board level; all flops clear on rst_n low.
- Reset values:
  - state=RUN, phase=0, tick_cnt=0, pwm_cnt=0, bright=all ones (255).
  - cmd_ready=0, running=1.
  - RGB_R=RGB_G=RGB_B=1 (all LEDs off).
- cmd_ready goes to 1 on the first clock after rst_n deasserts. It stays 1 thereafter; every command is single-cycle.
- Reset mid-operation: asserting rst_n at any point returns every register to its reset value immediately. No command is half-applied.
- Phase colour map (R,G,B lit):
  - 0 = 100 (red)
  - 1 = 110 (yellow)
  - 2 = 010 (green)
  - 3 = 011 (cyan)
  - 4 = 001 (blue)
  - 5 = 101 (magenta)
- State machine: RUN and PAUSE.
  - RUN: tick_cnt increments each cycle. At tick_cnt==STEP_TICKS-1, tick_cnt<=0 and phase advances.
  - PAUSE: tick_cnt and phase hold.
  - Phase advance is modulo 6; 5 wraps to 0.
- Command effects (on the accept cycle, effective next cycle):
  - RUN: state<=RUN; tick_cnt unchanged. RUN while already in RUN is a no-op.
  - PAUSE: state<=PAUSE, freezing tick_cnt at its current value. PAUSE while already in PAUSE is a no-op.
  - STEP: phase advances by one and tick_cnt<=0, in either state. State is unchanged.
  - SET_BRIGHT: bright<=cmd_data. Phase and timing are unaffected.
- Simultaneous events:
  - STEP on the same cycle as terminal count: phase advances exactly once and tick_cnt<=0.
  - PAUSE on the terminal-count cycle: the terminal-count advance still happens, then the block pauses with tick_cnt=0.
- PWM:
  - pwm_cnt is free-running modulo 2**PWM_BITS and runs in both states.
  - A channel is lit when its colour bit is set and pwm_cnt < bright.
  - bright=0 means always dark; bright=255 gives 255/256 duty.
- Output latency: RGB_* are registered, one cycle after the phase/pwm_cnt/bright values they reflect. phase and running are direct register outputs.
- Width rules:
  - tick_cnt width = $clog2(STEP_TICKS).
  - The PWM compare is unsigned, PWM_BITS wide.

Decomposition:
- Package rgb_wheel_pkg:
  - Enum cmd_op_t {OP_RUN, OP_PAUSE, OP_STEP, OP_SET_BRIGHT}.
  - Enum seq_state_t {S_RUN, S_PAUSE}.
  - Constant NUM_PHASES=6.
  - Function phase_to_rgb(phase) returning the 3-bit lit mask.
- Sub-module rgb_pwm:
  - Contains the free-running pwm_cnt and the compare logic.
  - Takes the lit mask and bright; produces registered active-low RGB_R/G/B.

Test Plan (bench overrides CLK_HZ=60, STEPS_PER_SEC=6, so STEP_TICKS=10; PWM_BITS=8):
- Reset release, no commands, bright=255 -> phase 0,1,2,3,4,5,0 at cycles 10,20,...,60 after reset. RGB pattern matches the map, with active-low pins low for lit colours whenever pwm_cnt<255.
- Hold rst_n low -> RGB_*=1, cmd_ready=0. Release -> cmd_ready=1 next cycle.
- At tick_cnt=4 issue PAUSE, wait 50 cycles, then RUN -> phase unchanged during the pause; next advance occurs 6 cycles after RUN is accepted.
- In PAUSE issue STEP three times -> phase 0->3, tick_cnt=0, running=0.
- Issue STEP on the cycle where tick_cnt=9 -> phase advances by exactly 1 and tick_cnt=0.
- SET_BRIGHT 64 in phase 0 -> RGB_R low for 64 of every 256 cycles; RGB_G and RGB_B stay high. SET_BRIGHT 0 -> all three pins stay high.

Source files
------------

// File: rtl/rgb_wheel_pkg.sv
// Shared types and colour-wheel helpers for the RGB wheel sequencer.
package rgb_wheel_pkg;

    typedef enum logic [1:0] {
        OP_RUN        = 2'd0,
        OP_PAUSE      = 2'd1,
        OP_STEP       = 2'd2,
        OP_SET_BRIGHT = 2'd3
    } cmd_op_t;

    typedef enum logic {
        S_RUN   = 1'b0,
        S_PAUSE = 1'b1
    } seq_state_t;

    localparam int         NUM_PHASES = 6;
    localparam int         PHASE_W    = 3;
    localparam int         RGB_W      = 3;
    localparam logic [2:0] LAST_PHASE = 3'd5;

    // Lit mask ordered {R,G,B}, active-high.
    function automatic logic [RGB_W-1:0] phase_to_rgb(input logic [PHASE_W-1:0] phase);
        logic [RGB_W-1:0] mask;
        case (phase)
            3'd0:    mask = 3'b100;
            3'd1:    mask = 3'b110;
            3'd2:    mask = 3'b010;
            3'd3:    mask = 3'b011;
            3'd4:    mask = 3'b001;
            3'd5:    mask = 3'b101;
            default: mask = 3'b000;
        endcase
        return mask;
    endfunction

    function automatic logic [PHASE_W-1:0] phase_inc(input logic [PHASE_W-1:0] phase);
        return (phase >= LAST_PHASE) ? 3'd0 : phase + 3'd1;
    endfunction

endpackage

// File: rtl/rgb_pwm.sv
// Global-brightness PWM: free-running counter gates the lit mask onto active-low pins.
// Latency: pins reflect lit/bright/counter one cycle later (registered outputs).
// Backpressure: none; consumes inputs every cycle.
module rgb_pwm
    import rgb_wheel_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [RGB_W-1:0]    i_lit,
    input  logic [PWM_BITS-1:0] i_bright,
    output logic [RGB_W-1:0]    o_rgb_n
);

    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [RGB_W-1:0]    r_rgb_n;
    logic                w_on;
    logic [RGB_W-1:0]    w_rgb_n_nxt;

    // Strict less-than: bright=0 is always dark, full scale leaves one dark slot.
    always_comb begin
        w_on        = (r_pwm_cnt < i_bright);
        w_rgb_n_nxt = ~(i_lit & {RGB_W{w_on}});
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pwm_cnt <= '0;
            r_rgb_n   <= '1;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
            r_rgb_n   <= w_rgb_n_nxt;
        end
    end

    assign o_rgb_n = r_rgb_n;

endmodule

// File: rtl/rgb_wheel_sequencer.sv
// Steps the RGB LED through a six-phase colour wheel with global PWM brightness.
// Latency: commands take effect the cycle after accept; pins lag phase by one cycle.
// Backpressure: cmd_ready is low only in reset; every command is single-cycle.
module rgb_wheel_sequencer
    import rgb_wheel_pkg::*;
#(
    parameter int CLK_HZ        = 12000000,
    parameter int STEPS_PER_SEC = 6,
    parameter int PWM_BITS      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [PWM_BITS-1:0] cmd_data,
    output logic [2:0]          phase,
    output logic                running,
    output logic                RGB_R,
    output logic                RGB_G,
    output logic                RGB_B
);

    localparam int STEP_TICKS = CLK_HZ / STEPS_PER_SEC;
    localparam int TICK_W     = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(STEP_TICKS - 1);

    seq_state_t          r_state;
    logic [PHASE_W-1:0]  r_phase;
    logic [TICK_W-1:0]   r_tick_cnt;
    logic [PWM_BITS-1:0] r_bright;
    logic                r_cmd_ready;

    seq_state_t          w_state_nxt;
    logic [PHASE_W-1:0]  w_phase_nxt;
    logic [TICK_W-1:0]   w_tick_nxt;
    logic [PWM_BITS-1:0] w_bright_nxt;
    cmd_op_t             w_op;
    logic                w_accept;
    logic                w_tc;
    logic                w_step;
    logic                w_freeze;
    logic [RGB_W-1:0]    w_lit;
    logic [RGB_W-1:0]    w_rgb_n;

    always_comb begin
        w_state_nxt  = r_state;
        w_phase_nxt  = r_phase;
        w_tick_nxt   = r_tick_cnt;
        w_bright_nxt = r_bright;

        w_op     = cmd_op_t'(cmd_op);
        w_accept = cmd_valid & r_cmd_ready;
        w_tc     = (r_state == S_RUN) && (r_tick_cnt == TICK_LAST);
        w_step   = w_accept && (w_op == OP_STEP);
        // A PAUSE freezes the count it sees, unless the terminal count wins this cycle.
        w_freeze = w_accept && (w_op == OP_PAUSE);

        if (w_step || w_tc) begin
            w_phase_nxt = phase_inc(r_phase);
            w_tick_nxt  = '0;
        end else if ((r_state == S_RUN) && !w_freeze) begin
            w_tick_nxt = r_tick_cnt + TICK_W'(1);
        end

        if (w_accept) begin
            case (w_op)
                OP_RUN:        w_state_nxt  = S_RUN;
                OP_PAUSE:      w_state_nxt  = S_PAUSE;
                OP_SET_BRIGHT: w_bright_nxt = cmd_data;
                default:       w_state_nxt  = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_RUN;
            r_phase     <= '0;
            r_tick_cnt  <= '0;
            r_bright    <= '1;
            r_cmd_ready <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_phase     <= w_phase_nxt;
            r_tick_cnt  <= w_tick_nxt;
            r_bright    <= w_bright_nxt;
            r_cmd_ready <= 1'b1;
        end
    end

    assign w_lit = phase_to_rgb(r_phase);

    rgb_pwm #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_lit    (w_lit),
        .i_bright (r_bright),
        .o_rgb_n  (w_rgb_n)
    );

    assign cmd_ready = r_cmd_ready;
    assign phase     = r_phase;
    assign running   = (r_state == S_RUN);
    assign RGB_R     = w_rgb_n[2];
    assign RGB_G     = w_rgb_n[1];
    assign RGB_B     = w_rgb_n[0];

endmodule
